// File: rtl/vga_pixel_feeder.sv
// Pixel-clock read side of the frame buffer: pops RGB words from a FWFT dual-clock FIFO and feeds the VGA stage.
// Latency: pix_rgb/underflow are registered, valid one cycle after their disp_en cycle; fifo_rinc is combinational.
// Backpressure: none toward the display; empty FIFO substitutes UFL_COLOR and the debt is repaid in blanking. Optional: VGA_FEEDER_STATS_EN.
module vga_pixel_feeder #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter logic [23:0] UFL_COLOR = 24'h000000
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [31:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_rfull,
    output logic        fifo_rinc,
    input  logic        disp_en,
    input  logic        sof,
    output logic [23:0] pix_rgb,
    output logic        locked,
    output logic        underflow,
    output logic [15:0] ufl_count
);
    localparam int unsigned  FRAME    = HDISP * VDISP;
    localparam int unsigned  DW       = $clog2(FRAME + 1);
    localparam logic [DW-1:0] DEBT_MAX = DW'(FRAME);

    typedef enum logic [1:0] {FILL, SYNC, RUN, REALIGN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] debt_q, debt_d;
    logic [23:0]   pix_rgb_q, pix_rgb_d;
    logic          underflow_q, underflow_d;

    logic pix_cyc;    // this cycle delivers a pixel (popped or substituted)
    logic ufl_cyc;    // pixel cycle with nothing in the FIFO
    logic drain_cyc;  // blanking cycle that discards one word to repay debt
    logic debt_full;  // this underflow would push debt to the ceiling
    logic frame_bad;  // frame-length checker demands resynchronisation

    // The top byte of the FIFO word carries no pixel data.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^fifo_rdata[31:24];

    // Qualify the current cycle: a pixel slot, an underflow, or a debt-repayment pop.
    always_comb begin
        pix_cyc   = disp_en && ((state_q == RUN) || (state_q == REALIGN) ||
                                ((state_q == SYNC) && sof));
        ufl_cyc   = pix_cyc && fifo_rempty;
        drain_cyc = (state_q == REALIGN) && !disp_en && (debt_q != '0) && !fifo_rempty;
        debt_full = ufl_cyc && (debt_q >= (DEBT_MAX - DW'(1)));
    end

    // State and output registers.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= FILL;
            debt_q      <= '0;
            pix_rgb_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            debt_q      <= debt_d;
            pix_rgb_q   <= pix_rgb_d;
            underflow_q <= underflow_d;
        end
    end

    // Next state and debt bookkeeping; a full debt or a bad frame forces a full resync.
    always_comb begin
        state_d = state_q;
        debt_d  = debt_q;
        if (ufl_cyc) begin
            debt_d = debt_q + DW'(1);
        end else if (drain_cyc) begin
            debt_d = debt_q - DW'(1);
        end
        case (state_q)
            FILL:    if (fifo_rfull) state_d = SYNC;
            SYNC:    if (sof) state_d = RUN;
            RUN:     if (!disp_en && (debt_q != '0)) state_d = REALIGN;
            REALIGN: if (debt_d == '0) state_d = RUN;
            default: state_d = FILL;
        endcase
        if (debt_full || frame_bad) begin
            state_d = FILL;
            debt_d  = '0;
        end
    end

    // Pop strobe and next pixel; anything outside a pixel slot shows black.
    always_comb begin
        fifo_rinc   = (pix_cyc && !fifo_rempty) || drain_cyc;
        pix_rgb_d   = '0;
        underflow_d = ufl_cyc;
        if (pix_cyc) begin
            pix_rgb_d = fifo_rempty ? UFL_COLOR : fifo_rdata[23:0];
        end
    end

    assign pix_rgb   = pix_rgb_q;
    assign underflow = underflow_q;
    assign locked    = (state_q == RUN) || (state_q == REALIGN);

`ifdef VGA_FEEDER_STATS_EN
    localparam int unsigned  FW        = $clog2(FRAME + 2);
    localparam logic [FW-1:0] FRAME_LEN = FW'(FRAME);

    logic [15:0]   ufl_count_q, ufl_count_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    // Saturating underflow counter and per-frame pixel-slot counter (saturates one past a full frame).
    always_comb begin
        ufl_count_d = ufl_count_q;
        if (ufl_cyc && (ufl_count_q != 16'hFFFF)) begin
            ufl_count_d = ufl_count_q + 16'd1;
        end
        frame_cnt_d = frame_cnt_q;
        if (pix_cyc && sof) begin
            frame_cnt_d = FW'(1);
        end else if (pix_cyc && (frame_cnt_q <= FRAME_LEN)) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ufl_count_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            ufl_count_q <= ufl_count_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_bad = sof && disp_en && locked && (frame_cnt_q != FRAME_LEN);
    assign ufl_count = ufl_count_q;
`else
    assign frame_bad = 1'b0;
    assign ufl_count = 16'h0000;
`endif

endmodule
